// File: rtl/types.sv
// Shared types for the memory access unit: the instruction descriptor that
// travels alongside each access, the FSM state encoding and the access-size
// encodings, plus the helper that folds dword accesses on a 32-bit bus.
package types;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mau_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } access_size_e;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_LOAD   = 2'd1,
    OP_STORE  = 2'd2,
    OP_BRANCH = 2'd3
  } op_e;

  typedef enum logic {
    STORE_REG_NONE = 1'b0,
    STORE_REG_RD   = 1'b1
  } store_reg_hazard_e;

  typedef struct packed {
    logic              is_valid;
    op_e               op;
    store_reg_hazard_e store_reg_hazard;
    logic [4:0]        rd_addr;
    logic [15:0]       pc;
  } InstructionDetails;

  // A 32-bit bus has no dword lane, so a dword request degrades to a word.
  function automatic logic [1:0] eff_size(input logic [1:0] size, input int data_w);
    if (data_w == 32 && size == SZ_DWORD) return SZ_WORD;
    return size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory access unit (purely combinational).
// Generates byte enables and replicated write data for stores, and extracts
// and sign/zero-extends the addressed lane of returned load data.
// size_i must already be folded to a size the bus supports.
module mem_lane_align #(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] lane_i,
  input  logic [1:0]                  size_i,
  input  logic                        uns_i,
  input  logic [DATA_W-1:0]           wsrc_i,
  input  logic [DATA_W-1:0]           rdata_i,
  output logic [DATA_W/8-1:0]         be_o,
  output logic [DATA_W-1:0]           wdata_o,
  output logic [DATA_W-1:0]           rdata_o
);

  localparam int NB = DATA_W / 8;

  logic [NB-1:0]     be_mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] up;
  int                sh;

  // Byte enables: (1 << size) ones moved up to the addressed lane.
  always_comb begin
    be_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << size_i)) be_mask[i] = 1'b1;
    end
    be_o = be_mask << lane_i;
  end

  // Store data: replicate the low byte/half/word across the whole bus.
  always_comb begin
    wdata_o = '0;
    case (size_i)
      2'd0: for (int i = 0; i < NB; i++)     wdata_o[i*8 +: 8]   = wsrc_i[7:0];
      2'd1: for (int i = 0; i < NB / 2; i++) wdata_o[i*16 +: 16] = wsrc_i[15:0];
      2'd2: for (int i = 0; i < NB / 4; i++) wdata_o[i*32 +: 32] = wsrc_i[31:0];
      default: wdata_o = wsrc_i;
    endcase
  end

  // Load data: bring the lane down to bit 0, park it at the top, then shift
  // back arithmetically or logically to extend it.
  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    sh      = DATA_W - (8 << size_i);
    up      = shifted << sh;
    if (uns_i) rdata_o = up >> sh;
    else       rdata_o = $signed(up) >>> sh;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a req/gnt/rvalid memory bus.
// Non-memory ops pass through in one cycle; loads and stores are issued from
// IDLE, wait for grant in REQ and (loads only) for data in WAIT, with a
// timeout that retires the load as a bus error.
// Build option: MEM_ACCESS_MISALIGN_TRAP_EN -- misaligned accesses trap
// instead of being aligned down to their size.
//
// state   | meaning
// IDLE    | accepting instructions; a mem op drives its request directly
// REQ     | latched request held on the bus until granted
// WAIT    | load granted, waiting for rvalid with a timeout down-counter
module mem_access_unit
  import types::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  InstructionDetails   details,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W-1:0]   rd,
  input  logic [1:0]          size,
  input  logic                unsigned_ld,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output InstructionDetails   out_details,
  output logic [DATA_W-1:0]   result,
  output logic                out_valid,
  output logic                misalign,
  output logic                bus_err
);

  localparam int NB    = DATA_W / 8;
  localparam int LW    = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mau_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  InstructionDetails det_q, det_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  InstructionDetails out_det_q, out_det_d;
  logic              out_valid_q, out_valid_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_q, misalign_d;

  logic              is_idle, cur_mem, cur_st, trap, issue, done;
  logic [1:0]        sz_eff;
  logic [LW-1:0]     size_mask;
  logic [ADDR_W-1:0] addr_al;
  logic [DATA_W-1:0] st_src;
  logic [LW-1:0]     al_lane;
  logic [1:0]        al_size;
  logic              al_uns;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata, al_rdata;

  assign is_idle   = (state_q == ST_IDLE);
  assign cur_mem   = details.is_valid && (details.op == OP_LOAD || details.op == OP_STORE);
  assign cur_st    = (details.op == OP_STORE);
  assign sz_eff    = eff_size(size, DATA_W);
  assign size_mask = LW'((1 << sz_eff) - 1);
  assign addr_al   = data[ADDR_W-1:0] & ~ADDR_W'(size_mask);
  assign st_src    = (details.store_reg_hazard == STORE_REG_RD) ? result_q : rd;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trap = cur_mem && |(data[LW-1:0] & size_mask);
`else
  assign trap = 1'b0;
`endif

  assign issue = is_idle && cur_mem && !trap;

  // In IDLE the lane logic sees the incoming op; otherwise the latched one.
  assign al_lane = is_idle ? addr_al[LW-1:0] : addr_q[LW-1:0];
  assign al_size = is_idle ? sz_eff : size_q;
  assign al_uns  = is_idle ? unsigned_ld : uns_q;

  mem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .lane_i  (al_lane),
    .size_i  (al_size),
    .uns_i   (al_uns),
    .wsrc_i  (st_src),
    .rdata_i (mem_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  assign mem_req   = !rst && (issue || state_q == ST_REQ);
  assign mem_we    = mem_req && (is_idle ? cur_st : we_q);
  assign mem_addr  = is_idle ? addr_al : addr_q;
  assign mem_be    = is_idle ? al_be : be_q;
  assign mem_wdata = is_idle ? al_wdata : wdata_q;
  // Upstream is held while an access is outstanding, released in the cycle
  // it completes so the next instruction lines up with the return to IDLE.
  assign stall     = !rst && (issue || !is_idle) && !done;

  assign result      = result_q;
  assign out_details = out_det_q;
  assign out_valid   = out_valid_q;
  assign bus_err     = bus_err_q;
  assign misalign    = misalign_q;

  // Next-state and retirement decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    det_d       = det_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_det_d   = out_det_q;
    out_valid_d = 1'b0;
    bus_err_d   = 1'b0;
    misalign_d  = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (details.is_valid && !cur_mem) begin
          result_d    = data;
          out_det_d   = details;
          out_valid_d = 1'b1;
        end else if (trap) begin
          result_d           = data;
          out_det_d          = details;
          out_det_d.is_valid = 1'b0;
          misalign_d         = 1'b1;
          out_valid_d        = 1'b1;
        end else if (issue) begin
          addr_d  = addr_al;
          be_d    = al_be;
          wdata_d = al_wdata;
          we_d    = cur_st;
          size_d  = sz_eff;
          uns_d   = unsigned_ld;
          det_d   = details;
          if (mem_gnt && cur_st) begin
            result_d    = DATA_W'(addr_al);
            out_det_d   = details;
            out_valid_d = 1'b1;
            done        = 1'b1;
          end else if (mem_gnt && mem_rvalid) begin
            result_d    = al_rdata;
            out_det_d   = details;
            out_valid_d = 1'b1;
            done        = 1'b1;
          end else if (mem_gnt) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(TIMEOUT - 1);
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (we_q || mem_rvalid) begin
            result_d    = we_q ? DATA_W'(addr_q) : al_rdata;
            out_det_d   = det_q;
            out_valid_d = 1'b1;
            done        = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(TIMEOUT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          result_d    = al_rdata;
          out_det_d   = det_q;
          out_valid_d = 1'b1;
          done        = 1'b1;
          state_d     = ST_IDLE;
        end else if (cnt_q == '0) begin
          result_d    = '0;
          out_det_d   = det_q;
          out_valid_d = 1'b1;
          bus_err_d   = 1'b1;
          done        = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      det_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_det_q   <= '0;
      out_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      det_q       <= det_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_det_q   <= out_det_d;
      out_valid_q <= out_valid_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (DATA_W=32, ADDR_W=20, TIMEOUT=15).
// Expected retirements are queued as each op is driven and compared when
// out_valid appears.
module tb_mem_access_unit;
  import types::*;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst;
  InstructionDetails details;
  logic [DW-1:0]     data, rd;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW/8-1:0]   mem_be;
  logic [DW-1:0]     mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [DW-1:0]     mem_rdata;
  logic              stall;
  InstructionDetails out_details;
  logic [DW-1:0]     result;
  logic              out_valid, misalign, bus_err;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic        berr;
    logic        mis;
    logic        dval;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .details     (details),
    .data        (data),
    .rd          (rd),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .out_details (out_details),
    .result      (result),
    .out_valid   (out_valid),
    .misalign    (misalign),
    .bus_err     (bus_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    details    = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic set_op(input op_e op, input logic [31:0] d, input logic [31:0] r,
                        input logic [1:0] sz, input logic uns,
                        input store_reg_hazard_e hz, input logic [15:0] pc);
    details                  = '0;
    details.is_valid         = 1'b1;
    details.op               = op;
    details.store_reg_hazard = hz;
    details.pc               = pc;
    data        = d;
    rd          = r;
    size        = sz;
    unsigned_ld = uns;
  endtask

  task automatic push(input logic [31:0] r, input logic chk, input logic be,
                      input logic ms, input logic dv, input logic [15:0] pc);
    exp_t e;
    e.res = r; e.chk_res = chk; e.berr = be; e.mis = ms; e.dval = dv; e.pc = pc;
    sb.push_back(e);
  endtask

  // Scoreboard: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_retire", 64'(out_valid), 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_res) check_eq("sb_result", 64'(result), 64'(e.res));
        check_eq("sb_bus_err", 64'(bus_err), 64'(e.berr));
        check_eq("sb_misalign", 64'(misalign), 64'(e.mis));
        check_eq("sb_det_valid", 64'(out_details.is_valid), 64'(e.dval));
        check_eq("sb_det_pc", 64'(out_details.pc), 64'(e.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    idle_in();
    set_op(OP_LOAD, 32'h10, 32'h0, 2'd2, 1'b0, STORE_REG_NONE, 16'h0);
    mem_gnt = 1'b1;
    step(); step();
    #2;
    check_eq("rst_mem_req", 64'(mem_req), 64'h0);
    check_eq("rst_stall", 64'(stall), 64'h0);
    check_eq("rst_result", 64'(result), 64'h0);
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_bus_err", 64'(bus_err), 64'h0);
    check_eq("rst_misalign", 64'(misalign), 64'h0);
    check_eq("rst_out_details", 64'(out_details), 64'h0);
    step();
    rst = 1'b0;
    idle_in();
    step();

    // ALU pass-through
    set_op(OP_ALU, 32'h1234, 32'h0, 2'd0, 1'b0, STORE_REG_NONE, 16'h1);
    #2;
    check_eq("alu_mem_req", 64'(mem_req), 64'h0);
    check_eq("alu_stall", 64'(stall), 64'h0);
    push(32'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1);
    step(); idle_in();
    check_eq("alu_out_valid", 64'(out_valid), 64'h1);
    check_eq("alu_result", 64'(result), 64'h1234);

    // Byte store, granted immediately
    set_op(OP_STORE, 32'h3, 32'hAB, 2'd0, 1'b0, STORE_REG_NONE, 16'h2);
    mem_gnt = 1'b1;
    #2;
    check_eq("sb_req", 64'(mem_req), 64'h1);
    check_eq("sb_we", 64'(mem_we), 64'h1);
    check_eq("sb_addr", 64'(mem_addr), 64'h3);
    check_eq("sb_be", 64'(mem_be), 64'h8);
    check_eq("sb_wdata", 64'(mem_wdata), 64'hABABABAB);
    check_eq("sb_stall", 64'(stall), 64'h0);
    push(32'h3, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2);
    step(); idle_in();

    // Half store forwarding the result register (currently 3)
    set_op(OP_STORE, 32'h6, 32'hDEAD, 2'd1, 1'b0, STORE_REG_RD, 16'h3);
    mem_gnt = 1'b1;
    #2;
    check_eq("fwd_be", 64'(mem_be), 64'hC);
    check_eq("fwd_wdata", 64'(mem_wdata), 64'h00030003);
    push(32'h6, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3);
    step(); idle_in();

    // Signed half load: grant on 3rd cycle, rvalid 3 cycles after grant
    set_op(OP_LOAD, 32'h2, 32'h0, 2'd1, 1'b0, STORE_REG_NONE, 16'h4);
    #2;
    check_eq("hl_req_idle", 64'(mem_req), 64'h1);
    check_eq("hl_we", 64'(mem_we), 64'h0);
    check_eq("hl_be", 64'(mem_be), 64'hC);
    check_eq("hl_stall_c0", 64'(stall), 64'h1);
    step(); #2;
    check_eq("hl_req_c1", 64'(mem_req), 64'h1);
    check_eq("hl_addr_c1", 64'(mem_addr), 64'h2);
    check_eq("hl_stall_c1", 64'(stall), 64'h1);
    step();
    mem_gnt = 1'b1;
    #2;
    check_eq("hl_stall_c2", 64'(stall), 64'h1);
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      check_eq("hl_stall_wait", 64'(stall), 64'h1);
      check_eq("hl_req_wait", 64'(mem_req), 64'h0);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001_0000;
    #2;
    check_eq("hl_stall_rvalid", 64'(stall), 64'h0);
    push(32'hFFFF8001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4);
    step(); idle_in();

    // Unsigned byte load, gnt and rvalid together in IDLE
    set_op(OP_LOAD, 32'h1, 32'h0, 2'd0, 1'b1, STORE_REG_NONE, 16'h5);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_F200;
    push(32'hF2, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5);
    step(); idle_in();

    // Signed byte load, gnt and rvalid together from REQ
    set_op(OP_LOAD, 32'h3, 32'h0, 2'd0, 1'b0, STORE_REG_NONE, 16'h6);
    step();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7F00_0000;
    #2;
    check_eq("req_addr", 64'(mem_addr), 64'h3);
    check_eq("req_stall_done", 64'(stall), 64'h0);
    push(32'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 16'h6);
    step(); idle_in();

    // Timeout: word load granted, rvalid never arrives
    set_op(OP_LOAD, 32'h8, 32'h0, 2'd2, 1'b0, STORE_REG_NONE, 16'h7);
    mem_gnt = 1'b1;
    push(32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h7);
    step();
    mem_gnt = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (cyc == 5) check_eq("to_stall_wait", 64'(stall), 64'h1);
      step();
      cyc++;
    end
    idle_in();
    check_eq("to_latency", 64'(cyc), 64'(TO + 1));
    check_eq("to_bus_err", 64'(bus_err), 64'h1);
    step();
    check_eq("to_bus_err_pulse", 64'(bus_err), 64'h0);
    check_eq("to_out_valid_pulse", 64'(out_valid), 64'h0);

    // Misaligned word load
    set_op(OP_LOAD, 32'h2, 32'h0, 2'd2, 1'b0, STORE_REG_NONE, 16'h8);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    #2;
    check_eq("mis_no_req", 64'(mem_req), 64'h0);
    push(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8);
    step(); idle_in();
    check_eq("mis_flag", 64'(misalign), 64'h1);
`else
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #2;
    check_eq("mis_req", 64'(mem_req), 64'h1);
    check_eq("mis_aligned_addr", 64'(mem_addr), 64'h0);
    check_eq("mis_be", 64'(mem_be), 64'hF);
    push(32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8);
    step(); idle_in();
    check_eq("mis_flag", 64'(misalign), 64'h0);
`endif

    // Dword store on a 32-bit bus behaves as a word
    set_op(OP_STORE, 32'h4, 32'h1122_3344, 2'd3, 1'b0, STORE_REG_NONE, 16'h9);
    mem_gnt = 1'b1;
    #2;
    check_eq("dw_be", 64'(mem_be), 64'hF);
    check_eq("dw_wdata", 64'(mem_wdata), 64'h11223344);
    check_eq("dw_addr", 64'(mem_addr), 64'h4);
    push(32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 16'h9);
    step(); idle_in();

    // Reset during WAIT, late rvalid must be ignored
    set_op(OP_LOAD, 32'h10, 32'h0, 2'd2, 1'b0, STORE_REG_NONE, 16'hA);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    rst = 1'b1;
    #2;
    check_eq("mrst_req", 64'(mem_req), 64'h0);
    check_eq("mrst_stall", 64'(stall), 64'h0);
    step();
    rst = 1'b0;
    idle_in();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_BABE;
    #2;
    check_eq("mrst_idle_stall", 64'(stall), 64'h0);
    check_eq("mrst_idle_req", 64'(mem_req), 64'h0);
    step(); step();
    mem_rvalid = 1'b0;
    check_eq("mrst_no_retire", 64'(out_valid), 64'h0);
    check_eq("mrst_result", 64'(result), 64'h0);

    step(); step();
    check_eq("sb_drain", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
